// File: rtl/i2s_pkg.sv
// i2s_pkg: shared sample width, channel encoding and receiver states for the I2S receive path.
package i2s_pkg;

  // Number of bits kept per channel word; later bits in a longer slot are dropped.
  localparam int I2S_SAMPLE_W = 16;

  // Word-select encoding on the wire: ws low carries the left channel.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_t;

  // Receiver framing state: SYNC until a word boundary is seen, RUN while tracking words.
  typedef enum logic {
    RX_SYNC = 1'b0,
    RX_RUN  = 1'b1
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: two-flop synchroniser for the asynchronous bclk/ws/sd pins plus bclk rising-edge
// detection. ws_s and sd_s come from the same synchronised cycle in which bclk_rise is flagged.
module i2s_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic bclk,
  input  logic ws,
  input  logic sd,
  output logic bclk_rise,
  output logic ws_s,
  output logic sd_s
);

  // Bit order inside the synchroniser vectors: {bclk, ws, sd}.
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       bclk_prev_q;

  // Two-stage synchroniser and a delayed copy of bclk for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      meta_q      <= {bclk, ws, sd};
      sync_q      <= meta_q;
      bclk_prev_q <= sync_q[2];
    end
  end

  assign bclk_rise = sync_q[2] & ~bclk_prev_q;
  assign ws_s      = sync_q[1];
  assign sd_s      = sync_q[0];

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: recovers 16-bit stereo sample pairs from an external I2S stream (bclk/ws/sd) that
// is asynchronous to clk, and presents completed left/right pairs on a valid/ready port.
// Optional feature: define I2S_RX_TIMEOUT_EN to enable bclk link-loss detection (TIMEOUT clk cycles
// without a bclk rise raises link_lost and forces re-synchronisation).
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W
`ifdef I2S_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 1024
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bclk,
  input  logic                ws,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                link_lost
);

  localparam int                CNT_W   = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_W);

  logic bclk_rise;
  logic ws_s;
  logic sd_s;

  i2s_rx_state_t       state_q,      state_d;
  i2s_ch_t             ws_prev_q,    ws_prev_d;
  logic [SAMPLE_W-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [SAMPLE_W-1:0] left_hold_q,  left_hold_d;
  logic                left_pend_q,  left_pend_d;
  logic [SAMPLE_W-1:0] left_data_q,  left_data_d;
  logic [SAMPLE_W-1:0] right_data_q, right_data_d;
  logic                valid_q,      valid_d;
  logic                overrun_q,    overrun_d;

  logic [SAMPLE_W-1:0] fin_shift;
  logic [CNT_W-1:0]    fin_cnt;
  logic [SAMPLE_W-1:0] fin_word;

`ifdef I2S_RX_TIMEOUT_EN
  localparam int               TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            link_lost_q, link_lost_d;
`endif

  i2s_rx_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bclk),
    .ws        (ws),
    .sd        (sd),
    .bclk_rise (bclk_rise),
    .ws_s      (ws_s),
    .sd_s      (sd_s)
  );

  // Framing, word assembly, pair hand-off and (optionally) link-loss supervision.
  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    left_hold_d  = left_hold_q;
    left_pend_d  = left_pend_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    fin_shift    = shift_q;
    fin_cnt      = cnt_q;
    fin_word     = '0;

    // A consumed pair drops valid unless a new pair reloads it below.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (bclk_rise) begin
      ws_prev_d = i2s_ch_t'(ws_s);
      case (state_q)
        RX_SYNC: begin
          if (ws_s != ws_prev_q) begin
            state_d = RX_RUN;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
        RX_RUN: begin
          if (ws_s == ws_prev_q) begin
            if (cnt_q < CNT_MAX) begin
              shift_d = {shift_q[SAMPLE_W-2:0], sd_s};
              cnt_d   = cnt_q + 1'b1;
            end
          end else begin
            // The bit on a ws change is the LSB of the word that is ending.
            if (cnt_q < CNT_MAX) begin
              fin_shift = {shift_q[SAMPLE_W-2:0], sd_s};
              fin_cnt   = cnt_q + 1'b1;
            end
            fin_word = fin_shift << (CNT_MAX - fin_cnt);
            shift_d  = '0;
            cnt_d    = '0;
            if (ws_prev_q == CH_LEFT) begin
              left_hold_d = fin_word;
              left_pend_d = 1'b1;
            end else if (left_pend_q) begin
              left_pend_d = 1'b0;
              if (!valid_q || out_ready) begin
                left_data_d  = left_hold_q;
                right_data_d = fin_word;
                valid_d      = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

`ifdef I2S_RX_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    link_lost_d = link_lost_q;
    if (bclk_rise) begin
      to_cnt_d    = '0;
      link_lost_d = 1'b0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_d == TO_MAX) begin
        link_lost_d = 1'b1;
        state_d     = RX_SYNC;
        shift_d     = '0;
        cnt_d       = '0;
        left_pend_d = 1'b0;
      end
    end
`endif
  end

  // State and datapath registers; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RX_SYNC;
      ws_prev_q    <= CH_LEFT;
      shift_q      <= '0;
      cnt_q        <= '0;
      left_hold_q  <= '0;
      left_pend_q  <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_prev_q    <= ws_prev_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      left_hold_q  <= left_hold_d;
      left_pend_q  <= left_pend_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef I2S_RX_TIMEOUT_EN
  // Link-loss counter and flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q    <= '0;
      link_lost_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      link_lost_q <= link_lost_d;
    end
  end

  assign link_lost = link_lost_q;
`else
  assign link_lost = 1'b0;
`endif

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed self-checking bench for i2s_receiver. Drives an I2S stream at
// bclk = clk/16 and compares captured pairs against hand-computed values.
// With I2S_RX_TIMEOUT_EN defined the DUT is built with TIMEOUT=64 and the link-loss case runs.
module tb_i2s_receiver;

  logic        clk;
  logic        reset_n;
  logic        bclk;
  logic        ws;
  logic        sd;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        link_lost;

  int checkCount;
  int errorCount;

  logic [15:0] capL [0:7];
  logic [15:0] capR [0:7];
  int          capCount;
  int          validCycles;
  int          holdViolations;
  logic        prevHold;
  logic [15:0] prevL;
  logic [15:0] prevR;

`ifdef I2S_RX_TIMEOUT_EN
  i2s_receiver #(.SAMPLE_W(16), .TIMEOUT(64)) dut (
`else
  i2s_receiver #(.SAMPLE_W(16)) dut (
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .bclk       (bclk),
    .ws         (ws),
    .sd         (sd),
    .left_data  (left_data),
    .right_data (right_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .link_lost  (link_lost)
  );

  // 25 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Global time bound so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Capture handshakes and watch that held data never moves while the consumer stalls.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) validCycles++;
      if (out_valid && out_ready && capCount < 8) begin
        capL[capCount] = left_data;
        capR[capCount] = right_data;
        capCount++;
      end
      if (prevHold && out_valid && (left_data != prevL || right_data != prevR))
        holdViolations++;
      prevHold = out_valid && !out_ready;
      prevL    = left_data;
      prevR    = right_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCapture();
    capCount       = 0;
    validCycles    = 0;
    holdViolations = 0;
    prevHold       = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    bclk    = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    #1;
    clearCapture();
  endtask

  // One bit period: bclk low for 8 clk with ws/sd changed, then high for 8 clk.
  task automatic sendBit(input logic wsBit, input logic sdBit);
    bclk = 1'b0;
    ws   = wsBit;
    sd   = sdBit;
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
    #1;
  endtask

  // MSB first; the LSB already carries the next channel's ws value.
  task automatic sendWord(input logic ch, input logic [23:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--)
      sendBit((i == 0) ? ~ch : ch, value[i]);
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input int nbits);
    sendWord(1'b0, l, nbits);
    sendWord(1'b1, r, nbits);
  endtask

  // A dummy right word that lets the receiver find a word boundary before real frames.
  task automatic leadIn();
    sendWord(1'b1, 24'h00FFFF, 16);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    out_ready  = 1'b1;
    clearCapture();

    // Reset state.
    doReset();
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_left", {16'd0, left_data}, 32'd0);
    checkOutput("rst_right", {16'd0, right_data}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("rst_linklost", {31'd0, link_lost}, 32'd0);

    // Two back-to-back pairs with a ready consumer.
    leadIn();
    applyStimulus(24'hA5C3, 24'h0F0F, 16);
    applyStimulus(24'h8001, 24'h7FFE, 16);
    checkOutput("t1_count", capCount, 32'd2);
    checkOutput("t1_l0", {16'd0, capL[0]}, 32'h0000A5C3);
    checkOutput("t1_r0", {16'd0, capR[0]}, 32'h00000F0F);
    checkOutput("t1_l1", {16'd0, capL[1]}, 32'h00008001);
    checkOutput("t1_r1", {16'd0, capR[1]}, 32'h00007FFE);
    checkOutput("t1_validcycles", validCycles, 32'd2);
    checkOutput("t1_overrun", {31'd0, overrun}, 32'd0);

    // Stream starts in the middle of a right word.
    doReset();
    for (int i = 4; i >= 0; i--) sendBit((i == 0) ? 1'b0 : 1'b1, 1'b1);
    checkOutput("t2_partial_none", capCount, 32'd0);
    applyStimulus(24'h1234, 24'h5678, 16);
    checkOutput("t2_count", capCount, 32'd1);
    checkOutput("t2_l", {16'd0, capL[0]}, 32'h00001234);
    checkOutput("t2_r", {16'd0, capR[0]}, 32'h00005678);

    // Stalled consumer over three frames.
    doReset();
    out_ready = 1'b0;
    leadIn();
    applyStimulus(24'h1111, 24'h2222, 16);
    checkOutput("t3_valid1", {31'd0, out_valid}, 32'd1);
    checkOutput("t3_ovr_after1", {31'd0, overrun}, 32'd0);
    applyStimulus(24'h3333, 24'h4444, 16);
    checkOutput("t3_ovr_after2", {31'd0, overrun}, 32'd1);
    checkOutput("t3_left_held2", {16'd0, left_data}, 32'h00001111);
    applyStimulus(24'h5555, 24'h6666, 16);
    checkOutput("t3_left_held3", {16'd0, left_data}, 32'h00001111);
    checkOutput("t3_right_held3", {16'd0, right_data}, 32'h00002222);
    checkOutput("t3_hold_moves", holdViolations, 32'd0);
    checkOutput("t3_no_capture", capCount, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t3_accept_l", {16'd0, capL[0]}, 32'h00001111);
    @(negedge clk);
    #1;
    checkOutput("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    applyStimulus(24'h7777, 24'h8888, 16);
    checkOutput("t3_count", capCount, 32'd2);
    checkOutput("t3_next_l", {16'd0, capL[1]}, 32'h00007777);
    checkOutput("t3_next_r", {16'd0, capR[1]}, 32'h00008888);
    checkOutput("t3_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Short and long slots.
    doReset();
    leadIn();
    applyStimulus(24'h000ABC, 24'h0005A5, 12);
    applyStimulus(24'hFEDCBA, 24'h123456, 24);
    checkOutput("t4_count", capCount, 32'd2);
    checkOutput("t4_l12", {16'd0, capL[0]}, 32'h0000ABC0);
    checkOutput("t4_r12", {16'd0, capR[0]}, 32'h00005A50);
    checkOutput("t4_l24", {16'd0, capL[1]}, 32'h0000FEDC);
    checkOutput("t4_r24", {16'd0, capR[1]}, 32'h00001234);

    // Reset pulse during bit 7 of a left word.
    doReset();
    leadIn();
    applyStimulus(24'hCAFE, 24'hBEEF, 16);
    checkOutput("t5_pre_count", capCount, 32'd1);
    for (int i = 15; i >= 9; i--) sendBit(1'b0, 1'b1);
    bclk = 1'b0;
    ws   = 1'b0;
    sd   = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_left", {16'd0, left_data}, 32'd0);
    checkOutput("t5_rst_right", {16'd0, right_data}, 32'd0);
    checkOutput("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    clearCapture();
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    for (int i = 7; i >= 0; i--) sendBit((i == 0) ? 1'b1 : 1'b0, 1'b1);
    sendWord(1'b1, 24'h00AAAA, 16);
    checkOutput("t5_resync_none", capCount, 32'd0);
    applyStimulus(24'h0123, 24'h4567, 16);
    checkOutput("t5_count", capCount, 32'd1);
    checkOutput("t5_l", {16'd0, capL[0]}, 32'h00000123);
    checkOutput("t5_r", {16'd0, capR[0]}, 32'h00004567);

`ifdef I2S_RX_TIMEOUT_EN
    // bclk stops after a left word; link loss must drop the pending left word.
    doReset();
    leadIn();
    sendWord(1'b0, 24'h9999, 16);
    repeat (55) @(negedge clk);
    #1;
    checkOutput("t6_before_timeout", {31'd0, link_lost}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("t6_link_lost", {31'd0, link_lost}, 32'd1);
    repeat (35) @(negedge clk);
    #1;
    checkOutput("t6_no_pair", capCount, 32'd0);
    sendBit(1'b1, 1'b0);
    checkOutput("t6_link_back", {31'd0, link_lost}, 32'd0);
    sendWord(1'b1, 24'h00AAAA, 15);
    checkOutput("t6_no_stale_pair", capCount, 32'd0);
    applyStimulus(24'h2468, 24'h1357, 16);
    checkOutput("t6_count", capCount, 32'd1);
    checkOutput("t6_l", {16'd0, capL[0]}, 32'h00002468);
    checkOutput("t6_r", {16'd0, capR[0]}, 32'h00001357);
`else
    // Without the timeout feature an idle link never reports loss.
    repeat (100) @(negedge clk);
    #1;
    checkOutput("t6_no_linklost", {31'd0, link_lost}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
